// File: rtl/regsr_cmd_sequencer.sv
// Command sequencer feeding the 8-bit set/reset register bank.
// Define REGSR_SEQ_TOGGLE_EN to build the read-modify-write TOGGLE path.
module regsr_cmd_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        global_reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [WIDTH-1:0]            cmd_mask,
  input  logic [WIDTH-1:0]            cmd_data,
  input  logic [WIDTH-1:0]            reg_q,
  output logic [WIDTH-1:0]            reg_data,
  output logic [WIDTH-1:0]            reg_write_enable,
  output logic [WIDTH-1:0]            reg_set,
  output logic [WIDTH-1:0]            reg_reset,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

`ifdef REGSR_SEQ_TOGGLE_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE
  } state_t;
`endif

  state_t state, state_n;

  logic [1:0]       op_mem   [FIFO_DEPTH];
  logic [WIDTH-1:0] mask_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty;
  logic          push, pop;

  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_mask, head_data;

  logic [WIDTH-1:0] we_n, set_n, clr_n, dat_n;

`ifdef REGSR_SEQ_TOGGLE_EN
  logic [WIDTH-1:0] tmask, tmask_n;
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
`endif

  assign full       = (level == LW'(FIFO_DEPTH));
  assign empty      = (level == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign fifo_level = level;
  assign busy       = !empty || (state != S_IDLE);

  assign head_op   = op_mem[rd_ptr];
  assign head_mask = mask_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Queue storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]   <= cmd_op;
      mask_mem[wr_ptr] <= cmd_mask;
      data_mem[wr_ptr] <= cmd_data;
    end
  end

  // Next state, pop and next pulse values.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    we_n    = '0;
    set_n   = '0;
    clr_n   = '0;
    dat_n   = '0;
`ifdef REGSR_SEQ_TOGGLE_EN
    tmask_n = tmask;
`endif
    case (state)
      S_IDLE, S_ISSUE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_ISSUE;
          unique case (head_op)
            OP_WRITE: begin
              we_n  = head_mask;
              dat_n = head_data;
            end
            OP_SET:   set_n = head_mask;
            OP_CLEAR: clr_n = head_mask;
            OP_TOGGLE: begin
`ifdef REGSR_SEQ_TOGGLE_EN
              state_n = S_SETTLE;
              tmask_n = head_mask;
`else
              state_n = S_ISSUE;
`endif
            end
          endcase
        end else begin
          state_n = S_IDLE;
        end
      end
`ifdef REGSR_SEQ_TOGGLE_EN
      S_SETTLE: begin
        we_n    = tmask;
        dat_n   = ~reg_q;
        state_n = S_ISSUE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // State, pointers, level and registered bank pulses.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state            <= S_IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      level            <= '0;
      reg_write_enable <= '0;
      reg_set          <= '0;
      reg_reset        <= '0;
      reg_data         <= '0;
`ifdef REGSR_SEQ_TOGGLE_EN
      tmask            <= '0;
`endif
    end else begin
      state            <= state_n;
      reg_write_enable <= we_n;
      reg_set          <= set_n;
      reg_reset        <= clr_n;
      reg_data         <= dat_n;
`ifdef REGSR_SEQ_TOGGLE_EN
      tmask            <= tmask_n;
`endif
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_regsr_cmd_sequencer.sv
// Bench for regsr_cmd_sequencer: vector table, corner sequences,
// and random traffic against a command-level bank model.
module tb_regsr_cmd_sequencer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         global_reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_mask, cmd_data;
  logic [W-1:0] reg_q;
  logic [W-1:0] reg_data, reg_write_enable, reg_set, reg_reset;
  logic         busy;
  logic [2:0]   fifo_level;

  logic [W-1:0] bank = 8'h00;

  regsr_cmd_sequencer #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk              (clk),
    .global_reset     (global_reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_mask         (cmd_mask),
    .cmd_data         (cmd_data),
    .reg_q            (reg_q),
    .reg_data         (reg_data),
    .reg_write_enable (reg_write_enable),
    .reg_set          (reg_set),
    .reg_reset        (reg_reset),
    .busy             (busy),
    .fifo_level       (fifo_level)
  );

  always #5 clk = ~clk;

  assign reg_q = bank;

  // Register bank: reset > set > write per bit.
  always_ff @(posedge clk) begin
    bank <= (((bank & ~reg_write_enable) | (reg_data & reg_write_enable))
             | reg_set) & ~reg_reset;
  end

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] mask, data;
    logic [W-1:0] we, st, rs, dat;
    logic [W-1:0] bank;
  } vec_t;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] mask, data;
  } cmd_t;

  vec_t tv[9];
  cmd_t sb[$];
  cmd_t all_cmds[$];

  int nvec = 0;
  int nerr = 0;

  function automatic logic [31:0] pk(input logic [7:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  function automatic logic [31:0] outs();
    return {reg_write_enable, reg_set, reg_reset, reg_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic bit invisible(input cmd_t c);
`ifdef REGSR_SEQ_TOGGLE_EN
    return c.mask == '0;
`else
    return (c.mask == '0) || (c.op == 2'b11);
`endif
  endfunction

  function automatic logic [W-1:0] apply(input logic [W-1:0] b,
                                         input cmd_t c);
    case (c.op)
      2'b00: return (b & ~c.mask) | (c.data & c.mask);
      2'b01: return b | c.mask;
      2'b10: return b & ~c.mask;
`ifdef REGSR_SEQ_TOGGLE_EN
      default: return b ^ c.mask;
`else
      default: return b;
`endif
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] op,
                       input logic [7:0] m, input logic [7:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_mask  = m;
    cmd_data  = d;
  endtask

  task automatic issue_one(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(1'b1, v.op, v.mask, v.data);
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    chk({nm, "_lvl"}, 32'(fifo_level), 32'd1);
    @(negedge clk);
`ifdef REGSR_SEQ_TOGGLE_EN
    if (v.op == 2'b11) begin
      chk({nm, "_settle"}, outs(), 32'h0);
      @(negedge clk);
    end
`endif
    chk({nm, "_pulse"}, outs(), pk(v.we, v.st, v.rs, v.dat));
    @(negedge clk);
    chk({nm, "_clr"}, outs(), 32'h0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_bank"}, 32'(bank), 32'(v.bank));
  endtask

  task automatic pulse_check();
    cmd_t c;
    logic [31:0] e;
    if ((reg_write_enable | reg_set | reg_reset) != '0) begin
      while (sb.size() > 0 && invisible(sb[0])) void'(sb.pop_front());
      if (sb.size() == 0) begin
        chk("rnd_spurious", outs(), 32'h0);
      end else begin
        c = sb.pop_front();
        case (c.op)
          2'b00:   e = pk(c.mask, 8'h00, 8'h00, c.data);
          2'b01:   e = pk(8'h00, c.mask, 8'h00, 8'h00);
          2'b10:   e = pk(8'h00, 8'h00, c.mask, 8'h00);
          default: e = pk(c.mask, 8'h00, 8'h00, ~bank);
        endcase
        chk("rnd_pulse", outs(), e);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic         rdy;
    logic [W-1:0] mb;
    int           left;

    tv[0] = '{2'd0, 8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'hA5};
    tv[1] = '{2'd1, 8'h0F, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h00, 8'hAF};
    tv[2] = '{2'd2, 8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'hAC};
    tv[3] = '{2'd0, 8'hF0, 8'h50, 8'hF0, 8'h00, 8'h00, 8'h50, 8'h5C};
    tv[4] = '{2'd0, 8'hFF, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'h3C};
`ifdef REGSR_SEQ_TOGGLE_EN
    tv[5] = '{2'd3, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hC3, 8'hC3};
    tv[6] = '{2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hC3};
    tv[7] = '{2'd3, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h3C, 8'hCC};
`else
    tv[5] = '{2'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};
    tv[6] = '{2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};
    tv[7] = '{2'd3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C};
`endif
    tv[8] = '{2'd2, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h0C};

    drive(1'b0, 2'b00, 8'h00, 8'h00);
    global_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_outs",  outs(),         32'h0);
    global_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", outs(), 32'h0);

    for (int i = 0; i < 9; i++) issue_one(tv[i], i);

    // Back-to-back SET, CLEAR, WRITE without bubbles.
    issue_one(tv[0], 100);
    @(negedge clk); drive(1'b1, 2'd1, 8'h0F, 8'h00);
    @(negedge clk); drive(1'b1, 2'd2, 8'h03, 8'h00);
    @(negedge clk); drive(1'b1, 2'd0, 8'hF0, 8'h50);
    chk("b2b_set", outs(), pk(8'h00, 8'h0F, 8'h00, 8'h00));
    @(negedge clk); drive(1'b0, 2'd0, 8'h00, 8'h00);
    chk("b2b_clr", outs(), pk(8'h00, 8'h00, 8'h03, 8'h00));
    @(negedge clk);
    chk("b2b_wr", outs(), pk(8'hF0, 8'h00, 8'h00, 8'h50));
    @(negedge clk);
    chk("b2b_idle", outs(), 32'h0);
    chk("b2b_busy", 32'(busy), 32'd0);
    chk("b2b_bank", 32'(bank), 32'h5C);

    // TOGGLE directly behind a WRITE reads the written value back.
    @(negedge clk); drive(1'b1, 2'd0, 8'hFF, 8'h00);
    @(negedge clk); drive(1'b1, 2'd3, 8'hFF, 8'h00);
    @(negedge clk); drive(1'b0, 2'd0, 8'h00, 8'h00);
    chk("tgl_wr", outs(), pk(8'hFF, 8'h00, 8'h00, 8'h00));
    @(negedge clk);
    chk("tgl_gap", outs(), 32'h0);
    @(negedge clk);
`ifdef REGSR_SEQ_TOGGLE_EN
    chk("tgl_pulse", outs(), pk(8'hFF, 8'h00, 8'h00, 8'hFF));
`else
    chk("tgl_pulse", outs(), 32'h0);
`endif
    @(negedge clk);
    chk("tgl_idle", outs(), 32'h0);
    chk("tgl_busy", 32'(busy), 32'd0);
`ifdef REGSR_SEQ_TOGGLE_EN
    chk("tgl_bank", 32'(bank), 32'hFF);
`else
    chk("tgl_bank", 32'(bank), 32'h00);
`endif

    // Reset with a SET in flight and a TOGGLE still queued.
    @(negedge clk); drive(1'b1, 2'd0, 8'hFF, 8'h5A);
    @(negedge clk); drive(1'b1, 2'd1, 8'h0F, 8'h00);
    @(negedge clk); drive(1'b1, 2'd3, 8'hFF, 8'h00);
    @(negedge clk); drive(1'b0, 2'd0, 8'h00, 8'h00);
    chk("mid_set",   outs(), pk(8'h00, 8'h0F, 8'h00, 8'h00));
    chk("mid_level", 32'(fifo_level), 32'd1);
    global_reset = 1'b1;
    #1;
    chk("arst_outs",  outs(), 32'h0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_busy",  32'(busy), 32'd0);
    @(negedge clk);
    global_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_quiet", outs(), 32'h0);
    end
    chk("arst_busy2", 32'(busy), 32'd0);
    chk("arst_bank",  32'(bank), 32'h5A);

    // Random traffic; bank value tracked per command, not per cycle.
    rdy = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      if (cmd_valid && rdy) begin
        sb.push_back('{cmd_op, cmd_mask, cmd_data});
        all_cmds.push_back('{cmd_op, cmd_mask, cmd_data});
      end
      pulse_check();
      chk("rnd_ready", 32'(cmd_ready), 32'(fifo_level != 3'(D)));
      rdy = cmd_ready;
      if (cyc < 650) begin
        drive($urandom_range(0, 9) < 7, 2'($urandom),
              ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
              8'($urandom));
      end else begin
        drive(1'b0, 2'd0, 8'h00, 8'h00);
      end
    end
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      pulse_check();
    end
    chk("rnd_drain", 32'(busy), 32'd0);
    chk("rnd_level", 32'(fifo_level), 32'd0);
    mb = 8'h5A;
    foreach (all_cmds[i]) mb = apply(mb, all_cmds[i]);
    chk("rnd_bank", 32'(bank), 32'(mb));
    left = 0;
    foreach (sb[i]) if (!invisible(sb[i])) left++;
    chk("rnd_lost", 32'(left), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
